// File: rtl/fir_channel_sched_if.sv
// Handshake bundle for the channel-scheduled FIR: per-channel sample inputs and
// the single filtered-result output stream.
interface fir_channel_sched_if #(
  parameter int W   = 8,
  parameter int NCH = 4
);
  logic [NCH-1:0]   in_valid;
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]   in_ready;
  logic [W:0]       y;
  logic [2:0]       y_ch;
  logic             y_valid;
  logic             y_ready;
  logic             busy;

  modport master (
    output in_valid, in_data, y_ready,
    input  in_ready, y, y_ch, y_valid, busy
  );

  modport slave (
    input  in_valid, in_data, y_ready,
    output in_ready, y, y_ch, y_valid, busy
  );
endinterface

// File: rtl/fir_channel_sched.sv
// Round-robin scheduler sharing one 4-tap shift-add MAC across NCH channels,
// each with a private delay line; one sample in flight, result held until taken.
module fir_channel_sched #(
  parameter int W   = 8,
  parameter int NCH = 4
) (
  input  logic                clk,
  input  logic                rst,
  fir_channel_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t         state;
  logic [W-1:0]   dl [NCH][4];
  logic [W:0]     acc;
  logic [1:0]     tap;
  logic [2:0]     ch;
  logic [2:0]     ptr;
  logic [W:0]     y;
  logic [2:0]     y_ch;
  logic           y_valid;

  logic [2:0]     win;
  logic           win_found;
  logic [3:0]     srch;
  logic [NCH-1:0] grant;
  logic [W-1:0]   sample;
  logic [W-1:0]   tap_raw;
  logic [W:0]     term;
  logic           accept;

  // Search order starts one past the last accepted channel and wraps.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    srch      = '0;
    for (int k = 0; k < NCH; k++) begin
      srch = 4'(ptr) + 4'(k) + 4'd1;
      if (srch >= 4'(NCH)) srch = srch - 4'(NCH);
      for (int c = 0; c < NCH; c++) begin
        if (!win_found && srch == 4'(c) && bus.in_valid[c]) begin
          win       = 3'(c);
          win_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant  = '0;
    sample = '0;
    for (int c = 0; c < NCH; c++) begin
      grant[c] = win_found && (win == 3'(c));
      if (win == 3'(c)) sample = bus.in_data[c*W +: W];
    end
  end

  always_comb begin
    tap_raw = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch == 3'(c)) tap_raw = dl[c][tap];
    end
    term = {1'b0, tap_raw} >> tap;
  end

  assign accept       = (state == IDLE) && win_found;
  assign bus.in_ready = (state == IDLE && rst) ? grant : '0;
  assign bus.y        = y;
  assign bus.y_ch     = y_ch;
  assign bus.y_valid  = y_valid;
  assign bus.busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      acc     <= '0;
      tap     <= '0;
      ch      <= '0;
      ptr     <= 3'(NCH - 1);
      y       <= '0;
      y_ch    <= '0;
      y_valid <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        for (int t = 0; t < 4; t++) dl[c][t] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            for (int c = 0; c < NCH; c++) begin
              if (win == 3'(c)) begin
                dl[c][3] <= dl[c][2];
                dl[c][2] <= dl[c][1];
                dl[c][1] <= dl[c][0];
                dl[c][0] <= sample;
              end
            end
            ch    <= win;
            ptr   <= win;
            y_ch  <= win;
            acc   <= '0;
            tap   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          // Last tap lands straight in y so the result is ready on entry to OUT.
          if (tap == 2'd3) begin
            y       <= acc + term;
            y_valid <= 1'b1;
            state   <= OUT;
          end else begin
            acc <= acc + term;
            tap <= tap + 2'd1;
          end
        end
        OUT: begin
          if (bus.y_ready) begin
            y_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_channel_sched.sv
// Directed bench for fir_channel_sched with a per-cycle transaction-level model.
module tb_fir_channel_sched;
  localparam int W   = 8;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_channel_sched_if #(.W(W), .NCH(NCH)) bus ();
  fir_channel_sched #(.W(W), .NCH(NCH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one transaction at a time, results appear 4 edges after accept.
  int hist [NCH][4];
  int ptr, wait_n, pend_y, pend_ch, last_y, last_ch, cyc;
  bit pend;
  int acc_cnt = 0, res_cnt = 0, acc_cyc = 0, vld_cyc = -1;
  int grant_q[$];
  int res_y_q[$];
  int res_ch_q[$];

  always @(negedge clk) begin
    int win, c, smp;
    bit exp_vld;
    logic [NCH-1:0] exp_rdy;
    cyc++;
    if (!rst) begin
      chk("rst_in_ready", int'(bus.in_ready), 0);
      chk("rst_y_valid", int'(bus.y_valid), 0);
      chk("rst_y", int'(bus.y), 0);
      chk("rst_y_ch", int'(bus.y_ch), 0);
      chk("rst_busy", int'(bus.busy), 0);
      for (int i = 0; i < NCH; i++) for (int t = 0; t < 4; t++) hist[i][t] = 0;
      ptr = NCH - 1; pend = 0; wait_n = 0; last_y = 0; last_ch = 0; vld_cyc = -1;
    end else begin
      win = -1;
      if (!pend) begin
        for (int k = 0; k < NCH; k++) begin
          c = (ptr + 1 + k) % NCH;
          if (win < 0 && bus.in_valid[c]) win = c;
        end
      end
      exp_rdy = '0;
      if (win >= 0) exp_rdy[win] = 1'b1;
      exp_vld = pend && (wait_n == 0);
      if (exp_vld) begin
        last_y = pend_y; last_ch = pend_ch;
      end
      chk("in_ready", int'(bus.in_ready), int'(exp_rdy));
      chk("y_valid", int'(bus.y_valid), int'(exp_vld));
      chk("y", int'(bus.y), last_y);
      chk("y_ch", int'(bus.y_ch), last_ch);
      chk("busy", int'(bus.busy), int'(pend));
      if (bus.y_valid && vld_cyc < 0) vld_cyc = cyc;
      if (pend && wait_n > 0) wait_n--;
      if (exp_vld && bus.y_ready) begin
        pend = 0;
        res_cnt++;
        res_y_q.push_back(int'(bus.y));
        res_ch_q.push_back(int'(bus.y_ch));
      end else if (win >= 0) begin
        smp = int'(bus.in_data[win*W +: W]);
        hist[win][3] = hist[win][2];
        hist[win][2] = hist[win][1];
        hist[win][1] = hist[win][0];
        hist[win][0] = smp;
        pend_y  = hist[win][0] + hist[win][1] / 2 + hist[win][2] / 4 + hist[win][3] / 8;
        pend_ch = win;
        last_ch = win;
        ptr = win; pend = 1; wait_n = 4;
        acc_cnt++;
        grant_q.push_back(win);
        acc_cyc = cyc + 1;
        vld_cyc = -1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int a0);
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick(1);
      if (acc_cnt != a0) ok = 1;
    end
    chk("accept_timeout", int'(ok), 1);
  endtask

  task automatic wait_res(input int r0, output int ry, output int rch);
    bit ok = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      tick(1);
      if (res_cnt != r0) ok = 1;
    end
    chk("result_timeout", int'(ok), 1);
    ry  = ok ? res_y_q[$] : -1;
    rch = ok ? res_ch_q[$] : -1;
  endtask

  task automatic send(input int c, input int s, output int ry, output int rch);
    int a0, r0;
    a0 = acc_cnt; r0 = res_cnt;
    bus.in_valid[c] = 1'b1;
    bus.in_data[c*W +: W] = 8'(s);
    wait_acc(a0);
    bus.in_valid[c] = 1'b0;
    wait_res(r0, ry, rch);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  initial begin
    int ry, rch, a0, r0, g0, q0;
    int imp[4];
    int fair_y[5];
    bit ok;
    imp = '{128, 64, 32, 16};
    fair_y = '{17, 32, 48, 64, 25};
    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.y_ready  = 1'b1;
    #1 rst = 1'b0;
    bus.in_valid[0] = 1'b1;
    tick(2);
    chk("reset_in_ready", int'(bus.in_ready), 0);
    chk("reset_busy", int'(bus.busy), 0);
    bus.in_valid[0] = 1'b0;
    rst = 1'b1;
    tick(1);

    // Impulse on ch0
    for (int i = 0; i < 4; i++) begin
      send(0, (i == 0) ? 'h80 : 0, ry, rch);
      chk("impulse_y", ry, imp[i]);
      chk("impulse_ch", rch, 0);
      if (i == 0) chk("impulse_latency", vld_cyc - acc_cyc, 4);
    end

    // Full-scale on ch1
    for (int i = 0; i < 4; i++) send(1, 'hFF, ry, rch);
    chk("max_y", ry, 476);
    chk("max_ch", rch, 1);

    // Floor on ch3
    send(3, 7, ry, rch);
    send(3, 7, ry, rch);
    chk("floor_y", ry, 10);
    chk("floor_ch", rch, 3);

    // Fairness with all channels requesting from reset
    do_reset();
    g0 = grant_q.size(); q0 = res_y_q.size();
    a0 = acc_cnt; r0 = res_cnt;
    bus.in_data = {8'h40, 8'h30, 8'h20, 8'h11};
    bus.in_valid = '1;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick(1);
      if (acc_cnt - a0 >= 5) ok = 1;
    end
    bus.in_valid = '0;
    chk("fair_timeout", int'(ok), 1);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick(1);
      if (res_cnt - r0 >= 5) ok = 1;
    end
    chk("fair_res_timeout", int'(ok), 1);
    if (ok) begin
      for (int i = 0; i < 5; i++) begin
        chk("fair_grant", grant_q[g0 + i], i % 4);
        chk("fair_y", res_y_q[q0 + i], fair_y[i]);
      end
    end
    send(2, 0, ry, rch);
    chk("indep_ch2_y", ry, 'h18);

    // Backpressure while another channel keeps requesting
    bus.y_ready = 1'b0;
    a0 = acc_cnt;
    bus.in_data[1*W +: W] = 8'd5;
    bus.in_valid[1] = 1'b1;
    wait_acc(a0);
    bus.in_valid[1] = 1'b0;
    bus.in_data[0 +: W] = 8'h22;
    bus.in_valid[0] = 1'b1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick(1);
      if (bus.y_valid) ok = 1;
    end
    chk("bp_valid_timeout", int'(ok), 1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("bp_y", int'(bus.y), 'h15);
      chk("bp_y_ch", int'(bus.y_ch), 1);
      chk("bp_y_valid", int'(bus.y_valid), 1);
      chk("bp_in_ready", int'(bus.in_ready), 0);
    end
    a0 = acc_cnt; r0 = res_cnt;
    bus.y_ready = 1'b1;
    tick(1);
    chk("bp_exit_valid", int'(bus.y_valid), 0);
    chk("bp_exit_in_ready", int'(bus.in_ready), 1);
    chk("bp_no_accept_exit", acc_cnt - a0, 0);
    tick(1);
    chk("bp_next_accept", acc_cnt - a0, 1);
    bus.in_valid[0] = 1'b0;
    wait_res(r0 + 1, ry, rch);
    chk("bp_next_y", ry, 46);

    // Reset during MAC tap 2
    a0 = acc_cnt;
    bus.in_data[0 +: W] = 8'h55;
    bus.in_valid[0] = 1'b1;
    wait_acc(a0);
    bus.in_valid[0] = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);
    chk("mac_rst_y", int'(bus.y), 0);
    chk("mac_rst_valid", int'(bus.y_valid), 0);
    rst = 1'b1;
    tick(8);
    send(0, 'h40, ry, rch);
    chk("post_rst_y", ry, 'h40);
    chk("post_rst_ch", rch, 0);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/fir_channel_sched.md
FIR_CHANNEL_SCHED -- requirements
Module: fir_channel_sched

Interface
REQ-001 Parameter: W, 8, sample width in bits.
REQ-002 Parameter: NCH, 4, number of input channels; legal range 2..8.
REQ-003 Port: clk  input  1  clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid  input  NCH  per-channel sample-valid.
REQ-006 Port: in_data  input  NCH*W  per-channel unsigned samples; channel c occupies bits [c*W +: W].
REQ-007 Port: in_ready  output  NCH  per-channel accept; at most one bit high.
REQ-008 Port: y  output  W+1  filtered result, unsigned.
REQ-009 Port: y_ch  output  3  channel index of y.
REQ-010 Port: y_valid  output  1  result valid.
REQ-011 Port: y_ready  input  1  downstream accept.
REQ-012 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-013 Block SHALL time-share one shift-add MAC among NCH channels, each channel owning a private 4-deep delay line d[c][0..3] of W bits.
REQ-014 Per-channel result SHALL be y = d0 + (d1>>1) + (d2>>2) + (d3>>3); each shift floors (LSBs discarded), sum in W+1 bits, no overflow possible.
REQ-015 FSM states SHALL be IDLE, MAC, OUT.
REQ-016 In IDLE, in_ready SHALL be one-hot on the round-robin winner among channels with in_valid high, else all zero; in MAC and OUT in_ready SHALL be all zero.
REQ-017 Round-robin: search starts at last-accepted channel +1, wrapping NCH-1 -> 0; pointer SHALL update only on an accept edge.
REQ-018 Accept = in_valid[c] & in_ready[c] at a rising edge: d[c] shifts (d3<=d2, d2<=d1, d1<=d0, d0<=sample), y_ch<=c, accumulator<=0, tap counter<=0, state->MAC.
REQ-019 MAC SHALL add exactly one term per cycle, tap 0..3, reading the updated delay line of the latched channel; state->OUT at the edge that adds tap 3.
REQ-020 Latency: y_valid SHALL rise exactly 4 clock edges after the accept edge; y holds final sum.
REQ-021 In OUT, y_valid SHALL stay high and y, y_ch stable until y_valid & y_ready at an edge; then state->IDLE, y_valid<=0.
REQ-022 y_ready while not in OUT SHALL be ignored.
REQ-023 No acceptance SHALL occur in the OUT-exit cycle; next accept earliest the following cycle (max throughput one sample per 6 cycles).
REQ-024 in_valid deasserting before acceptance SHALL be legal; the arbiter evaluates current in_valid only.
REQ-025 Delay lines of non-selected channels SHALL never change.
REQ-026 y and y_ch SHALL hold their last values outside OUT.

Reset
REQ-027 rst low SHALL immediately force state IDLE, all delay lines 0, accumulator 0, tap counter 0, y=0, y_ch=0, y_valid=0, busy=0, RR pointer=NCH-1 (channel 0 highest priority first).
REQ-028 Reset asserted during MAC or OUT SHALL discard the in-flight result with no y_valid pulse; in_ready SHALL be all zero while rst is low.

Verification
REQ-029 Impulse: ch0 samples 0x80,0,0,0 with y_ready=1 -> y=0x080,0x040,0x020,0x010, y_ch=0, each y_valid 4 edges after accept.
REQ-030 Max value: ch1 four samples 0xFF -> fourth y = 255+127+63+31 = 476 (0x1DC), no overflow.
REQ-031 Fairness: all four in_valid held high after reset -> grant order 0,1,2,3,0; each channel's delay line independent (ch2 history unaffected by ch0 data).
REQ-032 Backpressure: y_ready=0 for 10 cycles in OUT -> y, y_ch, y_valid stable, in_ready all zero; y_ready=1 -> IDLE next edge, next accept one cycle later.
REQ-033 Reset in MAC on tap 2 -> no y_valid, outputs 0; next ch0 sample 0x40 -> y=0x040 (history cleared).
REQ-034 Floor check: ch3 samples 7,7 -> second y = 7 + 3 = 10.
